// File: rtl/prog_mem_ctrl.sv
// Writable instruction memory for the pipelined MIPS IF stage: synchronous-read RAM
// with a fetch handshake, address-fault flag, post-reset NOP fill and a host load mode.
module prog_mem_ctrl #(
    parameter int               ADDR_BITS      = 8,
    parameter int               DATA_W         = 32,
    parameter logic [DATA_W-1:0] NOP_WORD      = 32'h0000_0000,
    parameter bit               CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_req,
    input  logic [31:0]          fetch_addr,
    output logic                 fetch_ready,
    output logic                 inst_valid,
    output logic [DATA_W-1:0]    instruction,
    output logic                 addr_fault,
    input  logic                 load_mode,
    input  logic                 load_we,
    input  logic [DATA_W-1:0]    load_data,
    output logic [ADDR_BITS:0]   load_count,
    output logic                 load_overflow
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   clr_ptr_q, clr_ptr_d;
    logic [ADDR_BITS:0]     load_count_q, load_count_d;
    logic                   load_overflow_q, load_overflow_d;
    logic                   inst_valid_q, inst_valid_d;
    logic                   addr_fault_q, addr_fault_d;
    logic [DATA_W-1:0]      instr_q, instr_d;

    logic [DATA_W-1:0]      mem_q [DEPTH];
    logic                   wr_req_s;
    logic                   mem_we_s;
    logic [ADDR_BITS-1:0]   mem_waddr_s;
    logic [DATA_W-1:0]      mem_wdata_s;

    logic [ADDR_BITS-1:0]   fetch_idx_s;
    logic                   fetch_fault_s;

    assign fetch_idx_s   = fetch_addr[ADDR_BITS+1:2];
    assign fetch_fault_s = (|fetch_addr[1:0]) | (|fetch_addr[31:ADDR_BITS+2]);

    // Reset must never disturb memory, even when a write is decoded in that cycle.
    assign mem_we_s = wr_req_s & reset;

    // Next-state, write-port and output decode.
    always_comb begin
        state_d         = state_q;
        clr_ptr_d       = clr_ptr_q;
        load_count_d    = load_count_q;
        load_overflow_d = load_overflow_q;
        inst_valid_d    = 1'b0;
        addr_fault_d    = 1'b0;
        instr_d         = instr_q;
        wr_req_s        = 1'b0;
        mem_waddr_s     = {ADDR_BITS{1'b0}};
        mem_wdata_s     = NOP_WORD;

        case (state_q)
            ST_CLEAR: begin
                wr_req_s    = 1'b1;
                mem_waddr_s = clr_ptr_q;
                mem_wdata_s = NOP_WORD;
                clr_ptr_d   = clr_ptr_q + ADDR_BITS'(1);
                if (clr_ptr_q == {ADDR_BITS{1'b1}}) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (fetch_req) begin
                    inst_valid_d = 1'b1;
                    if (fetch_fault_s) begin
                        instr_d      = NOP_WORD;
                        addr_fault_d = 1'b1;
                    end else begin
                        instr_d      = mem_q[fetch_idx_s];
                        addr_fault_d = 1'b0;
                    end
                end else begin
                    instr_d = instr_q;
                end
                // The fetch above still completes when the host asks for load mode.
                if (load_mode) begin
                    state_d         = ST_LOAD;
                    load_count_d    = {(ADDR_BITS+1){1'b0}};
                    load_overflow_d = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (load_we) begin
                    if (!load_count_q[ADDR_BITS]) begin
                        wr_req_s     = 1'b1;
                        mem_waddr_s  = load_count_q[ADDR_BITS-1:0];
                        mem_wdata_s  = load_data;
                        load_count_d = load_count_q + (ADDR_BITS+1)'(1);
                    end else begin
                        load_overflow_d = 1'b1;
                    end
                end else begin
                    load_count_d = load_count_q;
                end
                if (!load_mode) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            end
        endcase
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_ptr_q       <= {ADDR_BITS{1'b0}};
            load_count_q    <= {(ADDR_BITS+1){1'b0}};
            load_overflow_q <= 1'b0;
            inst_valid_q    <= 1'b0;
            addr_fault_q    <= 1'b0;
            instr_q         <= NOP_WORD;
        end else begin
            state_q         <= state_d;
            clr_ptr_q       <= clr_ptr_d;
            load_count_q    <= load_count_d;
            load_overflow_q <= load_overflow_d;
            inst_valid_q    <= inst_valid_d;
            addr_fault_q    <= addr_fault_d;
            instr_q         <= instr_d;
        end
    end

    // Single write port RAM; CLEAR and LOAD are exclusive states so there is no contention.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end else begin
            mem_q[mem_waddr_s] <= mem_q[mem_waddr_s];
        end
    end

    assign fetch_ready   = (state_q == ST_RUN);
    assign inst_valid    = inst_valid_q;
    assign addr_fault    = addr_fault_q;
    assign instruction   = instr_q;
    assign load_count    = load_count_q;
    assign load_overflow = load_overflow_q;

endmodule

// File: doc/prog_mem_ctrl.md
Name: prog_mem_ctrl

Overview:
- Parametrised, writable instruction memory for the pipelined MIPS core.
- Replaces a fixed combinational ROM with a synchronous-read RAM that has:
  - a fetch handshake;
  - an address-fault flag;
  - a post-reset clear sequence that fills memory with NOP;
  - a load mode so a host (UART bootloader) can stream a new program, such as Dijkstra test images, without resynthesis.
- Sits between the IF-stage PC and the IF/ID register.

Parameters:
- ADDR_BITS, 8, word-index width; DEPTH = 2^ADDR_BITS words (256 by default).
- DATA_W, 32, instruction width.
- NOP_WORD, 32'h00000000, fill and fault word (sll $0,$0,0).
- CLEAR_ON_RESET, 1:
  - 1: reset runs the CLEAR sequence.
  - 0: reset goes straight to RUN and keeps memory contents.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising clk edge resets the block.
- fetch_req  in  1  PC presents a fetch this cycle.
- fetch_addr  in  32  byte address from PC.
- fetch_ready  out  1  block accepts fetches (high only in RUN).
- inst_valid  out  1  instruction is valid this cycle.
- instruction  out  DATA_W  fetched word.
- addr_fault  out  1  fetched address was misaligned or out of range.
- load_mode  in  1  host requests program load.
- load_we  in  1  host write strobe (LOAD state only).
- load_data  in  DATA_W  word to write.
- load_count  out  ADDR_BITS+1  words written since LOAD entry.
- load_overflow  out  1  sticky: write attempted past DEPTH.

Behaviour:
- States: CLEAR, RUN, LOAD. Registered state; fetch_ready = (state==RUN), a combinational decode of state.
- Reset (reset==0 at edge), taking priority over everything and valid in any state, including mid-CLEAR and mid-LOAD:
  - state <= CLEAR if CLEAR_ON_RESET, else RUN;
  - clr_ptr <= 0, instruction <= NOP_WORD;
  - inst_valid, addr_fault, load_overflow <= 0; load_count <= 0.
  - Memory is untouched by reset itself.
- CLEAR:
  - Each cycle writes mem[clr_ptr] <= NOP_WORD, clr_ptr++.
  - When clr_ptr == DEPTH-1 is written, next state is RUN. The clear takes exactly DEPTH cycles.
  - fetch_req and load_mode are ignored; inst_valid = 0.
- RUN, fetch:
  - Latency is one cycle: a fetch_req sampled at edge N gives inst_valid=1 and instruction at edge N+1.
  - Throughput is one fetch per cycle, back-to-back.
- RUN, fetch index and fault:
  - index = fetch_addr[ADDR_BITS+1:2].
  - fault = (fetch_addr[1:0] != 0) OR (fetch_addr[31:ADDR_BITS+2] != 0).
  - On fault: instruction <= NOP_WORD, addr_fault <= 1, inst_valid <= 1.
  - Otherwise: instruction <= mem[index], addr_fault <= 0.
- RUN, no fetch_req: inst_valid <= 0, addr_fault <= 0, instruction holds its last value.
- RUN to LOAD:
  - load_mode==1 at an edge moves the state to LOAD next cycle and sets load_count <= 0 and load_overflow <= 0.
  - A fetch_req in the same cycle is still serviced; load_mode has lower priority than the fetch, which completes.
- LOAD, writes:
  - Each load_we with load_count < DEPTH writes mem[load_count] <= load_data, then load_count++.
  - load_we with load_count == DEPTH writes nothing and sets load_overflow <= 1 (sticky).
- LOAD, other inputs: fetch_req is ignored; inst_valid = 0, addr_fault = 0.
- LOAD to RUN:
  - load_mode==0 at an edge returns to RUN next cycle.
  - A load_we in that same cycle is still performed.
  - load_count and load_overflow hold until the next LOAD entry.
- Memory array: DEPTH x DATA_W, single write port, synchronous read, inferable as block RAM.
  - Writes come from the CLEAR or LOAD path, never both at once.
  - Read-during-write to the same index is impossible, because fetch and write states are exclusive.

Test Plan:
1. Clear sequence:
   - Stimulus: reset low 2 cycles, release. Count cycles until fetch_ready=1, then fetch 0x0, 0x3FC.
   - Required: fetch_ready=1 exactly 256 cycles after release; both reads return 32'h00000000 with inst_valid=1.
2. Load then fetch:
   - Stimulus: load_mode=1; write 32'h24100000, 32'h3c014000, 32'h34310010; load_mode=0. Fetch 0x0, 0x4, 0x8 on consecutive cycles.
   - Required: load_count=3; instructions appear one cycle after each request, in order, with inst_valid high 3 consecutive cycles.
3. Address faults:
   - Stimulus: fetch 0x00000002, then 0x00000400.
   - Required: both return NOP_WORD with addr_fault=1, inst_valid=1. A following fetch of 0x4 gives addr_fault=0.
4. Overflow:
   - Stimulus: in LOAD, write 257 words (value = index).
   - Required: load_count=256, load_overflow=1; mem[0]=0 and mem[255]=255 verified by fetch after return to RUN.
5. Simultaneous events:
   - Stimulus: fetch_req and load_mode both high in one RUN cycle.
   - Required: the fetch returns valid next cycle; the state is LOAD after that, and a subsequent fetch_req gets inst_valid=0.
6. Reset mid-LOAD:
   - Stimulus: after 10 writes, pull reset low one cycle.
   - Required (CLEAR_ON_RESET=1): load_count=0, fetch_ready=0 for 256 cycles, then mem[0..9] read back as NOP_WORD.
   - Required (CLEAR_ON_RESET=0): fetch_ready=1 the cycle after release and the 10 words are intact.
